// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Paced by a one-cycle baud tick; baud_en gates the baud generator while a frame is in flight.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 baud_en
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY == 2);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_en  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start && !busy) begin
            shift    <= data_in;
            par      <= (^data_in) ^ ODD;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            busy     <= 1'b1;
            baud_en  <= 1'b1;
            state    <= SYNC;
          end
        end
        // Wait one full tick so the start bit spans a complete baud interval.
        SYNC: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        // tx is loaded one bit ahead from the shift register so the line stays registered.
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
              if (PARITY != 0) begin
                tx    <= par;
                state <= PARITY_BIT;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY_BIT: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              busy    <= 1'b0;
              baud_en <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that sits directly downstream of baud_generator. It consumes the generator's one-cycle tick pulse (one pulse per bit period) and shifts a parallel byte out on the TX line as a standard UART frame: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. It drives baud_en back to the generator's enable input so the generator runs only while a frame is in flight.

Parameters:
DATA_BITS, 8, number of data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; the same clock as baud_generator.
rst_n  input  1  asynchronous, active-low reset.
tick  input  1  one-cycle baud pulse from baud_generator; one pulse per bit period.
start  input  1  request to transmit data_in; sampled every cycle.
data_in  input  DATA_BITS  word to send; sampled only in the accept cycle.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when the frame completes.
baud_en  output  1  enable for baud_generator; equals busy.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock edge needed):
  - tx=1, busy=0, done=0, baud_en=0.
  - state=IDLE; shift register and counters cleared.
- Registered outputs:
  - All outputs come from flops; none is combinational from inputs.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - A start sampled high with busy=0 is accepted: data_in latched into the shift register; next state SYNC; busy=1 and baud_en=1 from the next cycle.
  - tick is ignored in IDLE.
- SYNC:
  - tx=1; wait for the first tick, then go to START.
  - This aligns the start bit to a full tick interval.
  - A tick coinciding with the accept cycle is not counted.
- START:
  - tx=0 for one bit period; the next tick moves to DATA with bit_cnt=0.
- DATA:
  - tx=shift[0]; each tick shifts right and increments bit_cnt.
  - On the tick with bit_cnt=DATA_BITS-1: go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - tx = XOR of the latched data bits (even), or its inverse (odd); lasts one bit period.
  - Next tick goes to STOP.
- STOP:
  - tx=1 for STOP_BITS bit periods, counted with a stop counter.
  - On the final stop tick: state=IDLE, busy=0, done=1 for exactly one cycle.
- Bit period:
  - Each bit lasts exactly one tick-to-tick interval.
  - tx changes in the cycle after the tick edge (one-cycle registered latency).
- Frame length:
  - (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) ticks after the SYNC tick.
- start while busy=1: ignored; no queuing; the latched data is unchanged.
- Back-to-back frames: start is accepted in the cycle where done=1, because busy is already 0.
- tick wider than one cycle is illegal input; behaviour is undefined.
- Reset mid-frame:
  - The frame is abandoned and tx returns high immediately; a truncated frame on the line is acceptable.
  - No done pulse is generated.
- data_in changing after acceptance has no effect on the frame in flight.

Test Plan:
- Defaults, tick every 16 clk, start with data_in=0x55 → tx=1 until the first tick, then 0,1,0,1,0,1,0,1,0,1, each 16 clk. busy high from accept+1 through the final stop tick. One done pulse. baud_en tracks busy.
- PARITY=1, data_in=0x07 → parity bit 1. PARITY=2, data_in=0x07 → parity bit 0. Frame is 11 bit periods.
- STOP_BITS=2, data_in=0xA3 → data bits 1,1,0,0,0,1,0,1, then tx high for 2 bit periods before done. Total 11 periods after SYNC.
- start re-asserted with data_in=0xFF mid-frame of 0x55 → ignored; the 0x55 frame is unaltered; no second frame follows.
- start held high across done, second data_in=0x3C → second SYNC begins the cycle after done, with no idle gap beyond SYNC. Both frames decode correctly.
- rst_n pulled low during DATA bit 4 of 0x55 → tx=1, busy=0, baud_en=0 within the same cycle; no done pulse. A new start after release sends a complete frame.
